// File: rtl/seq_multiplier_n_if.sv
// Operand/result handshake bundle for the shift-add sequential multiplier.
// Both channels use valid/ready: a transfer happens on a rising clk edge
// where valid and ready are both high; the source holds its payload stable
// while valid is high and ready is low.
interface seq_multiplier_n_if #(
   parameter int WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_signed;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_data;
   logic                 busy;

   // Producer of operands and consumer of results
   modport master (
      output in_valid, in_signed, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   // The multiplier itself
   modport slave (
      input  in_valid, in_signed, in_a, in_b, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/seq_multiplier_n.sv
// Shift-add sequential multiplier, one partial product per clock.
// Signed mode sign-extends the multiplicand and subtracts the last partial
// product, because the multiplier MSB carries weight -2^(WIDTH-1).
// The state register is exposed on o_dbg_state for checkers.
module seq_multiplier_n #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic               clk,
   input  logic               rst_n,
   seq_multiplier_n_if.slave  io_bus,
   output logic [1:0]         o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [2*WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]     r_b;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_signed;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic                 r_busy;
   logic [2*WIDTH-1:0]   r_out_data;

   logic                 w_last;
   logic                 w_sub;
   logic [2*WIDTH-1:0]   w_acc_next;
   logic [2*WIDTH-1:0]   w_a_ext;

   assign w_last  = (r_cnt == CNT_W'(WIDTH-1));
   assign w_sub   = r_signed & w_last;
   assign w_a_ext = io_bus.in_signed ? {{WIDTH{io_bus.in_a[WIDTH-1]}}, io_bus.in_a}
                                     : {{WIDTH{1'b0}}, io_bus.in_a};

   // Next accumulator value for the current iteration
   always_comb begin
      w_acc_next = r_acc;
      if (r_b[0]) begin
         w_acc_next = w_sub ? (r_acc - r_a) : (r_acc + r_a);
      end
   end

   // Control FSM and datapath registers, outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_signed    <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_out_data  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (io_bus.in_valid && r_in_ready) begin
                  r_a        <= w_a_ext;
                  r_b        <= io_bus.in_b;
                  r_signed   <= io_bus.in_signed;
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_state    <= S_CALC;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            S_CALC: begin
               r_acc <= w_acc_next;
               r_a   <= r_a << 1;
               r_b   <= r_b >> 1;
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_acc_next;
               end
            end
            S_DONE: begin
               // out_data keeps its value after the handoff
               if (io_bus.out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign io_bus.in_ready  = r_in_ready;
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.out_data  = r_out_data;
   assign io_bus.busy      = r_busy;
   assign o_dbg_state      = r_state;

endmodule

// File: doc/seq_multiplier_n.md
Name: seq_multiplier_n

Overview:
Parametrised shift-add sequential multiplier: the next generation of the team's 4-bit iterative multiplier. Accepts WIDTH-bit operands via a valid/ready handshake, supports unsigned or signed (two's-complement) mode per transaction, and computes one partial product per cycle. Holds the 2*WIDTH-bit result until the consumer accepts it. Sits beside datapath blocks in the embedded-systems lab designs as a low-area multiply unit.

Parameters:
WIDTH, 8, operand width in bits (>=2)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, do not override)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands (IDLE)
in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
in_a  input  WIDTH  multiplicand
in_b  input  WIDTH  multiplier
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_data  output  2*WIDTH  product
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, counter=0, internal operand regs=0. Reset mid-operation aborts the operation; no result is produced.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready, capture the operands. In unsigned mode: a_reg = zero-extend(in_a) to 2*WIDTH and b_reg = in_b. In signed mode: a_reg = sign-extend(in_a), and b_reg = in_b. Clear the accumulator, set cnt=0 and go to CALC.
- CALC (exactly WIDTH cycles): on each cycle, if b_reg[0], acc += a_reg (mod 2^(2*WIDTH)). Then a_reg <<= 1, b_reg >>= 1, cnt++.
- Signed correction: in signed mode on the final iteration (cnt==WIDTH-1), the MSB of in_b has weight -2^(WIDTH-1). In that case acc -= a_reg instead of adding.
- After the iteration with cnt==WIDTH-1, go to DONE. out_data takes the final acc value in the same clock edge.
- DONE: out_valid=1 and out_data stays stable. When out_ready=1, go to IDLE the next cycle. out_valid drops and out_data holds its last value; it is not cleared.
- Latency: accept edge to out_valid=1 is WIDTH+1 clock edges. Throughput is one product per WIDTH+2 cycles when out_ready is tied high.
- in_ready=0 in CALC and DONE. Inputs presented then are ignored and must remain held by the producer; no back-to-back accept.
- in_a, in_b and in_signed are sampled only at the accept edge. Changes during CALC do not affect the result.
- Zero operand: the block still runs the full WIDTH cycles; there is no early termination.
- Arithmetic: the result is exact for all operand pairs. The unsigned range is 0..(2^WIDTH-1)^2. The signed extreme (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) fits without overflow.
- busy = (state != IDLE).

Test Plan:
- WIDTH=8, unsigned: a=0xFF, b=0xFF, accept at cycle 0 → out_valid at cycle 9, out_data=0xFE01. With out_ready=1, in_ready is back high at cycle 10.
- WIDTH=8, signed: a=0x80 (-128), b=0x80 (-128) → out_data=0x4000. Signed a=0xFD (-3), b=0x05 → out_data=0xFFF1 (-15).
- Backpressure: out_ready=0 for 5 cycles after out_valid → out_valid and out_data stay stable and in_ready stays 0. Raising out_ready then returns the block to IDLE in one cycle.
- Mid-CALC stimulus: change in_a/in_b and pulse in_valid during CALC with a=3, b=7 captured → result 21, and the second request is not accepted.
- Async reset asserted at CALC iteration 3 → all outputs go to reset values immediately. After release, a new transaction a=12, b=10 yields 120.
- WIDTH=4 instance, exhaustive: all 256 pairs in both modes are checked against a reference model, each with latency 5.
